seq_divider: RTL and testbench
==============================

# seq_divider

Iterative radix-2 non-restoring integer divider, the inverse datapath to the team's Booth/CSA multiplier. Accepts one dividend/divisor pair per valid/ready handshake, produces one quotient bit per clock and returns a truncated quotient and remainder after WIDTH+2 cycles. It sits beside the multiplier in the arithmetic unit and shares its operand width parameter.

## Interface
- WIDTH, 8, operand, quotient and remainder width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider idle and able to accept operands
- dividend  input  WIDTH  dividend, two's complement when is_signed=1
- divisor  input  WIDTH  divisor, two's complement when is_signed=1
- is_signed  input  1  1 = signed division, 0 = unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  quotient, truncated toward zero
- remainder  output  WIDTH  remainder, sign follows dividend
- div_zero  output  1  divisor was zero for this result

## Operation
- States: IDLE, CALC, CORR, DONE. in_ready = (state==IDLE), combinational from state.
- IDLE: on in_valid&in_ready capture operands and is_signed. Signed mode: store |dividend|, |divisor|, neg_q = sign(dividend)^sign(divisor), neg_r = sign(dividend). Load iteration counter with WIDTH, partial remainder (WIDTH+1 bits) with 0. Go to CALC.
- CALC: one non-restoring step per cycle: shift {P,Q} left one bit; if P≥0 subtract divisor magnitude, else add it; new quotient LSB = ~P[WIDTH]. Decrement counter; after WIDTH steps go to CORR.
- CORR: if P<0 add divisor magnitude back to P. Apply sign fixup (negate Q if neg_q, negate P if neg_r). Apply special-case overrides. Register quotient/remainder/div_zero, go to DONE.
- DONE: out_valid=1; quotient, remainder, div_zero held stable. On out_valid&out_ready go to IDLE. No new operands accepted in the same cycle.
- Special cases (override the iterative result):
  - divisor==0: quotient = all ones, remainder = dividend (original, unsigned bits), div_zero=1.
  - signed overflow (dividend = 1 followed by WIDTH-1 zeros, divisor = all ones, is_signed=1): quotient = dividend, remainder = 0, div_zero=0.
- Input operands are ignored outside IDLE; changes to them mid-operation have no effect.

## Timing
- Reset (async, any state, including mid-CALC): state=IDLE, out_valid=0, quotient=0, remainder=0, div_zero=0, counter=0; in_ready=1 while reset asserted and after release. An operation in flight is discarded.
- Handshake at edge 0 → CALC cycles 1..WIDTH → CORR cycle WIDTH+1 → out_valid=1 from cycle WIDTH+2.
- out_valid holds until accepted; out_ready high in the first DONE cycle → in_ready=1 on the next cycle. Minimum issue interval WIDTH+3 cycles.
- in_valid while in_ready=0: no effect, nothing queued.
- All outputs registered; no combinational path from inputs to outputs except none (in_ready depends only on state).

## Configuration
- DIV_EARLY_OUT_EN defined: divide-by-zero and signed-overflow detected in IDLE at the accepting edge; FSM jumps directly to DONE with the override result; out_valid=1 on cycle 1 (latency 1).
- Not defined: special cases run the full CALC/CORR sequence; overrides applied in CORR; latency WIDTH+2 for every operation. Result values are identical in both builds.

## Test plan
- Unsigned, WIDTH=8: dividend=200, divisor=7, is_signed=0 → quotient=28 (0x1C), remainder=4, div_zero=0, out_valid exactly on cycle 10.
- Signed: dividend=-7 (0xF9), divisor=2 → quotient=-3 (0xFD), remainder=-1 (0xFF); dividend=7, divisor=-2 → quotient=0xFD, remainder=0x01.
- Divide by zero: dividend=0x5A, divisor=0 → quotient=0xFF, remainder=0x5A, div_zero=1; out_valid on cycle 1 with DIV_EARLY_OUT_EN, cycle 10 without.
- Signed overflow: dividend=0x80, divisor=0xFF, is_signed=1 → quotient=0x80, remainder=0x00; same operands unsigned → quotient=0x00, remainder=0x80.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, in_valid pulses ignored; release → next op accepted one cycle after out handshake.
- Reset mid-operation: assert rst_n=0 on cycle 4 of CALC → out_valid=0, outputs 0 immediately; after release new op 100/7 unsigned → quotient=14, remainder=2.

Source files
------------

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 non-restoring integer divider
//
// Purpose: accepts one dividend/divisor pair per in_valid/in_ready handshake.
// Produces one quotient bit per clock, then returns a quotient truncated
// toward zero and a remainder whose sign follows the dividend.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   dividend, divisor   WIDTH-bit operands, two's complement when is_signed=1
//   is_signed           1 = signed division, 0 = unsigned
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   quotient, remainder WIDTH-bit registered result
//   div_zero            registered flag: divisor was zero for this result
//
// Optional feature: define DIV_EARLY_OUT_EN to resolve divide-by-zero and
// signed overflow at the accepting edge (latency 1) instead of running the
// full WIDTH+2 cycle sequence. Result values are identical in both builds.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int               CW      = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;          // signed partial remainder
  logic [WIDTH-1:0] a_q, a_d;          // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] b_q, b_d;          // divisor magnitude
  logic [WIDTH-1:0] raw_q, raw_d;      // original dividend bits for the overrides
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_flag_q, zero_flag_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic             dvd_neg, dvs_neg, in_zero, in_ovf;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   p_shift, p_step, p_fix;
  logic [WIDTH-1:0] rem_mag, quo_fin, rem_fin;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

  // Operand conditioning and datapath arithmetic.
  always_comb begin
    dvd_neg = is_signed & dividend[WIDTH-1];
    dvs_neg = is_signed & divisor[WIDTH-1];
    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
    dvs_mag = dvs_neg ? (~divisor + ONE) : divisor;
    in_zero = (divisor == '0);
    in_ovf  = is_signed && (dividend == MIN_NEG) && (divisor == '1);

    // WIDTH+1 bits suffice: the step result always lands in [-D, D), so any
    // wrap in the intermediate shifted value cancels modulo 2^(WIDTH+1).
    p_shift = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
    p_step  = p_q[WIDTH] ? (p_shift + {1'b0, b_q}) : (p_shift - {1'b0, b_q});

    p_fix   = p_q[WIDTH] ? (p_q + {1'b0, b_q}) : p_q;
    rem_mag = p_fix[WIDTH-1:0];
    quo_fin = neg_quo_q ? (~a_q + ONE) : a_q;
    rem_fin = neg_rem_q ? (~rem_mag + ONE) : rem_mag;
  end

  // Next-state and register updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    a_d         = a_q;
    b_d         = b_q;
    raw_d       = raw_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_flag_d = zero_flag_q;
    ovf_flag_d  = ovf_flag_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dz_d        = dz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d         = dvd_mag;
          b_d         = dvs_mag;
          raw_d       = dividend;
          neg_quo_d   = dvd_neg ^ dvs_neg;
          neg_rem_d   = dvd_neg;
          zero_flag_d = in_zero;
          ovf_flag_d  = in_ovf;
          p_d         = '0;
          cnt_d       = CW'(WIDTH);
          state_d     = CALC;
`ifdef DIV_EARLY_OUT_EN
          if (in_zero || in_ovf) begin
            quo_d   = in_zero ? '1 : dividend;
            rem_d   = in_zero ? dividend : '0;
            dz_d    = in_zero;
            cnt_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        p_d   = p_step;
        a_d   = {a_q[WIDTH-2:0], ~p_step[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = CORR;
      end
      CORR: begin
        if (zero_flag_q) begin
          quo_d = '1;
          rem_d = raw_q;
          dz_d  = 1'b1;
        end else if (ovf_flag_q) begin
          quo_d = raw_q;
          rem_d = '0;
          dz_d  = 1'b0;
        end else begin
          quo_d = quo_fin;
          rem_d = rem_fin;
          dz_d  = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ov_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      raw_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_flag_q <= 1'b0;
      ovf_flag_q  <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      a_q         <= a_d;
      b_q         <= b_d;
      raw_q       <= raw_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_flag_q <= zero_flag_d;
      ovf_flag_q  <= ovf_flag_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

  localparam int W = 8;
  localparam int FULL_LAT = W + 2;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dz, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.lat = lat;
    return e;
  endfunction

  // Reference model built on the simulator's own integer division.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa, sbv;
    e.dz = 1'b0;
    e.lat = FULL_LAT;
    sa = $signed(a);
    sbv = $signed(b);
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = SPECIAL_LAT;
    end else if (s && sa == -(1 << (W-1)) && sbv == -1) begin
      e.q = a; e.r = '0; e.lat = SPECIAL_LAT;
    end else if (s) begin
      e.q = W'(sa / sbv);
      e.r = W'(sa % sbv);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Called at a sample point with in_ready high; returns one cycle after the
  // handshake edge, with garbage on the operand inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
    dividend = a; divisor = b; is_signed = s; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic wait_out(output int cyc, output bit timed_out);
    cyc = 1;
    timed_out = 1'b0;
    while (out_valid !== 1'b1) begin
      if (cyc >= 40) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_during: in_ready=%b out_valid=%b q=%h r=%h dz=%b, want 1 0 00 00 0",
               in_ready, out_valid, quotient, remainder, div_zero);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_after: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_unsigned();
    int cyc; bit to; exp_t e;
    issue(8'd200, 8'd7, 1'b0, mk(8'h1C, 8'd4, 1'b0, FULL_LAT));
    wait_out(cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
      failures++;
      $display("FAIL unsigned_200_7: q=%h r=%h dz=%b timeout=%0d, want q=%h r=%h dz=%b",
               quotient, remainder, div_zero, to, e.q, e.r, e.dz);
    end
    checks++;
    if (cyc != e.lat) begin
      failures++;
      $display("FAIL unsigned_latency: out_valid on cycle %0d, want %0d", cyc, e.lat);
    end
    accept();
  endtask

  task automatic test_signed();
    logic [W-1:0] ops [2][2];
    logic [W-1:0] wants [2][2];
    int cyc; bit to; exp_t e;
    ops[0][0] = 8'hF9; ops[0][1] = 8'h02; wants[0][0] = 8'hFD; wants[0][1] = 8'hFF;
    ops[1][0] = 8'h07; ops[1][1] = 8'hFE; wants[1][0] = 8'hFD; wants[1][1] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i][0], ops[i][1], 1'b1, mk(wants[i][0], wants[i][1], 1'b0, FULL_LAT));
      wait_out(cyc, to);
      e = exp_q.pop_front();
      checks++;
      if (to || quotient !== e.q || remainder !== e.r || div_zero !== e.dz || cyc != e.lat) begin
        failures++;
        $display("FAIL signed_%0d: q=%h r=%h dz=%b cyc=%0d timeout=%0d, want q=%h r=%h dz=%b cyc=%0d",
                 i, quotient, remainder, div_zero, cyc, to, e.q, e.r, e.dz, e.lat);
      end
      accept();
    end
  endtask

  task automatic test_div_zero();
    int cyc; bit to; exp_t e;
    issue(8'h5A, 8'h00, 1'b0, mk(8'hFF, 8'h5A, 1'b1, SPECIAL_LAT));
    wait_out(cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
      failures++;
      $display("FAIL div_zero: q=%h r=%h dz=%b timeout=%0d, want q=%h r=%h dz=%b",
               quotient, remainder, div_zero, to, e.q, e.r, e.dz);
    end
    checks++;
    if (cyc != e.lat) begin
      failures++;
      $display("FAIL div_zero_latency: out_valid on cycle %0d, want %0d", cyc, e.lat);
    end
    accept();
  endtask

  task automatic test_overflow();
    int cyc; bit to; exp_t e;
    issue(8'h80, 8'hFF, 1'b1, mk(8'h80, 8'h00, 1'b0, SPECIAL_LAT));
    wait_out(cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || quotient !== e.q || remainder !== e.r || div_zero !== e.dz || cyc != e.lat) begin
      failures++;
      $display("FAIL signed_overflow: q=%h r=%h dz=%b cyc=%0d, want q=%h r=%h dz=%b cyc=%0d",
               quotient, remainder, div_zero, cyc, e.q, e.r, e.dz, e.lat);
    end
    accept();
    issue(8'h80, 8'hFF, 1'b0, mk(8'h00, 8'h80, 1'b0, FULL_LAT));
    wait_out(cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || quotient !== e.q || remainder !== e.r || div_zero !== e.dz || cyc != e.lat) begin
      failures++;
      $display("FAIL unsigned_80_ff: q=%h r=%h dz=%b cyc=%0d, want q=%h r=%h dz=%b cyc=%0d",
               quotient, remainder, div_zero, cyc, e.q, e.r, e.dz, e.lat);
    end
    accept();
  endtask

  task automatic test_backpressure();
    int cyc; bit to; exp_t e;
    issue(8'd200, 8'd7, 1'b0, mk(8'h1C, 8'd4, 1'b0, FULL_LAT));
    wait_out(cyc, to);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      dividend = W'($urandom);
      divisor = W'($urandom);
      @(posedge clk); #1;
      checks++;
      if (to || out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== e.q ||
          remainder !== e.r || div_zero !== e.dz) begin
        failures++;
        $display("FAIL backpressure_hold_%0d: ov=%b ir=%b q=%h r=%h dz=%b, want 1 0 q=%h r=%h dz=%b",
                 i, out_valid, in_ready, quotient, remainder, div_zero, e.q, e.r, e.dz);
      end
    end
    in_valid = 1'b0;
    accept();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    issue(8'd100, 8'd7, 1'b0, mk(8'd14, 8'd2, 1'b0, FULL_LAT));
    wait_out(cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || quotient !== e.q || remainder !== e.r || div_zero !== e.dz || cyc != e.lat) begin
      failures++;
      $display("FAIL backpressure_next_op: q=%h r=%h dz=%b cyc=%0d, want q=%h r=%h dz=%b cyc=%0d",
               quotient, remainder, div_zero, cyc, e.q, e.r, e.dz, e.lat);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; exp_t e;
    issue(8'd250, 8'd3, 1'b0, mk(8'd83, 8'd1, 1'b0, FULL_LAT));
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    void'(exp_q.pop_front());
    #1;
    checks++;
    if ({out_valid, in_ready, quotient, remainder, div_zero} !== {1'b0, 1'b1, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_op: ov=%b ir=%b q=%h r=%h dz=%b, want 0 1 00 00 0",
               out_valid, in_ready, quotient, remainder, div_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'd100, 8'd7, 1'b0, mk(8'd14, 8'd2, 1'b0, FULL_LAT));
    wait_out(cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || quotient !== e.q || remainder !== e.r || div_zero !== e.dz || cyc != e.lat) begin
      failures++;
      $display("FAIL reset_mid_next_op: q=%h r=%h dz=%b cyc=%0d, want q=%h r=%h dz=%b cyc=%0d",
               quotient, remainder, div_zero, cyc, e.q, e.r, e.dz, e.lat);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; exp_t e;
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom);
      b = (i % 5 == 4) ? '0 : W'($urandom_range(1, 255));
      s = 1'($urandom);
      if (i == 7) begin a = 8'h80; b = 8'hFF; s = 1'b1; end
      issue(a, b, s, model(a, b, s));
      wait_out(cyc, to);
      e = exp_q.pop_front();
      checks++;
      if (to || quotient !== e.q || remainder !== e.r || div_zero !== e.dz || cyc != e.lat) begin
        failures++;
        $display("FAIL random_%0d %h/%h s=%b: q=%h r=%h dz=%b cyc=%0d, want q=%h r=%h dz=%b cyc=%0d",
                 i, a, b, s, quotient, remainder, div_zero, cyc, e.q, e.r, e.dz, e.lat);
      end
      accept();
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL random_%0d_ready: in_ready=%b, want 1", i, in_ready);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
